nv_ram_rws_param: RTL

- Parametrised successor to the fixed 128x128 read/write-separate RAM models: one write port, one read port, single clock.
- Adds byte-masked writes, a registered read with defined read-during-write forwarding, and a post-reset hardware clear sequencer.
- Adds an output valid flag.
- Used in the FPGA RAM model set wherever NVDLA configurations need non-128 width or depth.

---
 rtl/nv_ram_rws_param_if.sv | 27 ++
 rtl/nv_ram_rws_param.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/nv_ram_rws_param_if.sv
// nv_ram_rws_param_if: read/write/status bundle for the parametrised RWS RAM.
// The RAM drives dout, dout_vld and init_done. The requester drives all other signals.
interface nv_ram_rws_param_if #(
    parameter int unsigned DW = 128,
    parameter int unsigned AW = 7
);
    logic [AW-1:0]   ra;
    logic            re;
    logic [DW-1:0]   dout;
    logic            dout_vld;
    logic [AW-1:0]   wa;
    logic            we;
    logic [DW-1:0]   di;
    logic [DW/8-1:0] wmask;
    logic            init_done;
    logic [31:0]     pwrbus_ram_pd;

    modport master (
        output ra, re, wa, we, di, wmask, pwrbus_ram_pd,
        input  dout, dout_vld, init_done
    );

    modport slave (
        input  ra, re, wa, we, di, wmask, pwrbus_ram_pd,
        output dout, dout_vld, init_done
    );
endinterface

// File: rtl/nv_ram_rws_param.sv
// nv_ram_rws_param: parametrised one-write/one-read RAM model.
// It supports byte-masked writes and a registered read with same-address forwarding.
// A clear sequencer writes zero to every word after reset.
// Optional macro NV_RAM_RWS_OUT_REG_EN adds a second output register, which makes read latency 2.
module nv_ram_rws_param #(
    parameter int unsigned DW     = 128,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned AW     = 7,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    nv_ram_rws_param_if.slave   bus
);
    localparam int unsigned NB = DW / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   clr_addr_q;
    logic [AW-1:0]   clr_addr_d;
    logic            init_done_q;

    logic [DW-1:0]   mem [DEPTH];

    logic            ready_c;
    logic            wr_in_range_c;
    logic            rd_in_range_c;
    logic            wr_en_c;
    logic            rd_en_c;
    logic [NB-1:0]   fwd_mask_c;

    logic [DW-1:0]   rd_data_q;
    logic            rd_vld_q;

    logic            unused_pwrbus;

    // Clear-sequencer register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= (state_d == READY);
        end
    end

    // Next-state logic: walk every address once, then stay in READY until reset.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d    = READY;
                    clr_addr_d = '0;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // Decode port requests. Traffic is only accepted once the clear is complete.
    always_comb begin
        ready_c       = (state_q == READY);
        wr_in_range_c = (32'(bus.wa) < DEPTH);
        rd_in_range_c = (32'(bus.ra) < DEPTH);
        wr_en_c       = ready_c && bus.we && wr_in_range_c;
        rd_en_c       = ready_c && bus.re;
        fwd_mask_c    = '0;
        if (BYPASS && rd_en_c && wr_en_c && (bus.ra == bus.wa)) begin
            fwd_mask_c = bus.wmask;
        end
    end

    // Storage write port. The clear sequencer owns the port while it is running.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem[clr_addr_q] <= '0;
            end else if (wr_en_c) begin
                for (int i = 0; i < int'(NB); i++) begin
                    if (bus.wmask[i]) begin
                        mem[bus.wa][8*i +: 8] <= bus.di[8*i +: 8];
                    end
                end
            end
        end
    end

    // Registered read. Forwarded bytes are merged into the read register, not read from memory asynchronously.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_vld_q <= rd_en_c;
            if (rd_en_c) begin
                if (rd_in_range_c) begin
                    for (int i = 0; i < int'(NB); i++) begin
                        rd_data_q[8*i +: 8] <= fwd_mask_c[i] ? bus.di[8*i +: 8]
                                                             : mem[bus.ra][8*i +: 8];
                    end
                end else begin
                    rd_data_q <= '0;
                end
            end
        end
    end

`ifdef NV_RAM_RWS_OUT_REG_EN
    logic [DW-1:0] out_data_q;
    logic          out_vld_q;

    // Second output stage. It is flushed by reset together with the read stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            out_data_q <= rd_data_q;
            out_vld_q  <= rd_vld_q;
        end
    end

    assign bus.dout     = out_data_q;
    assign bus.dout_vld = out_vld_q;
`else
    assign bus.dout     = rd_data_q;
    assign bus.dout_vld = rd_vld_q;
`endif

    assign bus.init_done = init_done_q;

    // The power-down bus has no functional effect in this model.
    assign unused_pwrbus = ^bus.pwrbus_ram_pd;
endmodule
